// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared-memory MIPS datapath.
// The controller drives the control word; the datapath supplies opcode and memory ready.
interface multicycle_controller_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 4
);
  logic [OP_W-1:0]    op;
  logic               mem_ready;
  logic               mem_req;
  logic               IorD;
  logic               MemWrite;
  logic               IRWrite;
  logic               PCWrite;
  logic               Branch;
  logic [1:0]         PCSrc;
  logic               AluSrcA;
  logic [1:0]         AluSrcB;
  logic [ALUOP_W-1:0] AluOp;
  logic               RegDst;
  logic               MemtoReg;
  logic               RegWrite;
  logic               instr_done;
  logic               illegal_op;
  logic [3:0]         state;

  modport master (
    input  op, mem_ready,
    output mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, AluSrcA,
           AluSrcB, AluOp, RegDst, MemtoReg, RegWrite, instr_done, illegal_op, state
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, AluSrcA,
           AluSrcB, AluOp, RegDst, MemtoReg, RegWrite, instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM sequencing the multicycle MIPS datapath, with memory-ready stalls.
// The per-state control word is registered on entry; only ready/opcode-qualified strobes are combinational.
module multicycle_controller #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_RTYPEEX = 4'd6, S_RTYPEWB = 4'd7,
    S_IEX     = 4'd8,  S_IWB     = 4'd9,  S_BEQEX  = 4'd10, S_JEX   = 4'd11
  } state_t;

  typedef struct packed {
    logic               mem_req;
    logic               iord;
    logic               mem_write;
    logic               pc_write;
    logic               branch;
    logic [1:0]         pc_src;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               done;
  } ctl_t;

  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(4'b0000);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(4'b0010);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(4'b0110);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4'b0111);
  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(4'b1111);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);

  function automatic logic legal_op(input logic [OP_W-1:0] o);
    case (o)
      OP_R, OP_J, OP_BEQ, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  endfunction

  function automatic state_t next_of(input state_t s, input logic [OP_W-1:0] o, input logic rdy);
    next_of = S_FETCH;
    case (s)
      S_FETCH:  next_of = rdy ? S_DECODE : S_FETCH;
      S_DECODE:
        case (o)
          OP_R:                             next_of = S_RTYPEEX;
          OP_LW, OP_SW:                     next_of = S_MEMADR;
          OP_BEQ:                           next_of = S_BEQEX;
          OP_J:                             next_of = S_JEX;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: next_of = S_IEX;
          default:                          next_of = S_FETCH;
        endcase
      S_MEMADR:  next_of = (o == OP_LW) ? S_MEMRD : (o == OP_SW) ? S_MEMWR : S_FETCH;
      S_MEMRD:   next_of = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:   next_of = rdy ? S_FETCH : S_MEMWR;
      S_RTYPEEX: next_of = S_RTYPEWB;
      S_IEX:     next_of = S_IWB;
      default:   next_of = S_FETCH;
    endcase
  endfunction

  // Control word for a state; IEX picks its ALU op from the already-latched opcode.
  function automatic ctl_t ctl_of(input state_t s, input logic [OP_W-1:0] o);
    ctl_of = '0;
    case (s)
      S_FETCH:   begin ctl_of.mem_req = 1'b1; ctl_of.alu_src_b = 2'b01; ctl_of.alu_op = ALU_ADD; end
      S_DECODE:  begin ctl_of.alu_src_b = 2'b11; ctl_of.alu_op = ALU_ADD; end
      S_MEMADR:  begin ctl_of.alu_src_a = 1'b1; ctl_of.alu_src_b = 2'b10; ctl_of.alu_op = ALU_ADD; end
      S_MEMRD:   begin ctl_of.mem_req = 1'b1; ctl_of.iord = 1'b1; end
      S_MEMWB:   begin ctl_of.reg_write = 1'b1; ctl_of.mem_to_reg = 1'b1; ctl_of.done = 1'b1; end
      S_MEMWR:   begin ctl_of.mem_req = 1'b1; ctl_of.iord = 1'b1; ctl_of.mem_write = 1'b1; end
      S_RTYPEEX: begin ctl_of.alu_src_a = 1'b1; ctl_of.alu_op = ALU_R; end
      S_RTYPEWB: begin ctl_of.reg_write = 1'b1; ctl_of.reg_dst = 1'b1; ctl_of.done = 1'b1; end
      S_IEX: begin
        ctl_of.alu_src_a = 1'b1;
        ctl_of.alu_src_b = 2'b10;
        case (o)
          OP_SLTI: ctl_of.alu_op = ALU_SLT;
          OP_ANDI: ctl_of.alu_op = ALU_AND;
          OP_ORI:  ctl_of.alu_op = ALU_OR;
          default: ctl_of.alu_op = ALU_ADD;
        endcase
      end
      S_IWB:     begin ctl_of.reg_write = 1'b1; ctl_of.done = 1'b1; end
      S_BEQEX: begin
        ctl_of.alu_src_a = 1'b1;
        ctl_of.alu_op    = ALU_SUB;
        ctl_of.branch    = 1'b1;
        ctl_of.pc_src    = 2'b01;
        ctl_of.done      = 1'b1;
      end
      S_JEX:     begin ctl_of.pc_write = 1'b1; ctl_of.pc_src = 2'b10; ctl_of.done = 1'b1; end
      default:   ctl_of = '0;
    endcase
  endfunction

  state_t st;
  ctl_t   ctl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= S_FETCH;
      ctl <= ctl_of(S_FETCH, '0);
    end else begin
      st  <= next_of(st, bus.op, bus.mem_ready);
      ctl <= ctl_of(next_of(st, bus.op, bus.mem_ready), bus.op);
    end
  end

  // Opcode is not yet in the IR when DECODE is entered, so the illegal check stays combinational.
  logic live, is_fetch, illegal;
  assign live     = ~reset;
  assign is_fetch = (st == S_FETCH);
  assign illegal  = (st == S_DECODE) && !legal_op(bus.op);

  assign bus.mem_req    = live & ctl.mem_req;
  assign bus.IorD       = live & ctl.iord;
  assign bus.MemWrite   = live & ctl.mem_write;
  assign bus.IRWrite    = live & is_fetch & bus.mem_ready;
  assign bus.PCWrite    = live & (ctl.pc_write | (is_fetch & bus.mem_ready));
  assign bus.Branch     = live & ctl.branch;
  assign bus.PCSrc      = {2{live}} & ctl.pc_src;
  assign bus.AluSrcA    = live & ctl.alu_src_a;
  assign bus.AluSrcB    = {2{live}} & ctl.alu_src_b;
  assign bus.AluOp      = {ALUOP_W{live}} & ctl.alu_op;
  assign bus.RegDst     = live & ctl.reg_dst;
  assign bus.MemtoReg   = live & ctl.mem_to_reg;
  assign bus.RegWrite   = live & ctl.reg_write;
  assign bus.instr_done = live & (ctl.done | ((st == S_MEMWR) & bus.mem_ready) | illegal);
  assign bus.illegal_op = live & illegal;
  assign bus.state      = {4{live}} & st;
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences the shared single-memory MIPS datapath over multiple cycles.
- Supported instructions: R-type, j, beq, addi, slti, andi, ori, lw, sw.
- Replaces one-shot opcode decoding with per-state control words.
- Stalls on a memory ready handshake.
- Sits between the instruction register opcode field and the datapath mux, enable and ALU controls.

Parameters:
OP_W  6  opcode width
ALUOP_W  4  ALU operation code width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op  in  OP_W  opcode from instruction register (stable after FETCH)
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
IorD  out  1  0 = PC address, 1 = ALU-out address
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
PCWrite  out  1  unconditional PC load
Branch  out  1  PC load if ALU zero
PCSrc  out  2  00 = ALU result, 01 = ALU-out register, 10 = jump target
AluSrcA  out  1  0 = PC, 1 = register A
AluSrcB  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2
AluOp  out  ALUOP_W  ALU operation code
RegDst  out  1  1 = rd, 0 = rt
MemtoReg  out  1  1 = memory data, 0 = ALU-out
RegWrite  out  1  register file write
instr_done  out  1  one-cycle pulse in final cycle of each instruction
illegal_op  out  1  one-cycle pulse on unsupported opcode
state  out  4  current state encoding (debug)

Behaviour:
- The state register resets asynchronously to FETCH (0).
- While reset is high, every output is 0, including mem_req and state. The outputs are the state decode gated by ~reset.
- Reset asserted mid-instruction abandons it; there are no partial writes after reset asserts.
- Any unlisted control output is 0 in that state.
- AluOp codes: add = 0010, sub = 0110, and = 0000, or = 0001, slt = 0111, R-type (funct-decoded) = 1111.
- Opcodes: R = 000000, j = 000010, beq = 000100, addi = 001000, slti = 001010, andi = 001100, ori = 001101, lw = 100011, sw = 101011.
- States and outputs (encoding in brackets):
  - FETCH(0): mem_req = 1, IorD = 0, AluSrcA = 0, AluSrcB = 01, AluOp = 0010, PCSrc = 00. IRWrite = PCWrite = mem_ready. Stay in FETCH while !mem_ready; go to DECODE on mem_ready.
  - DECODE(1): AluSrcA = 0, AluSrcB = 11, AluOp = 0010 (precomputes branch target).
    - R → RTYPEEX; lw/sw → MEMADR; beq → BEQEX; j → JEX; addi/slti/andi/ori → IEX.
    - Other opcodes → FETCH, with illegal_op = 1 and instr_done = 1.
  - MEMADR(2): AluSrcA = 1, AluSrcB = 10, AluOp = 0010. lw → MEMRD; sw → MEMWR.
  - MEMRD(3): mem_req = 1, IorD = 1. Wait for mem_ready, then go to MEMWB.
  - MEMWB(4): RegWrite = 1, RegDst = 0, MemtoReg = 1, instr_done = 1. Go to FETCH.
  - MEMWR(5): mem_req = 1, IorD = 1, MemWrite = 1 (held while waiting). On mem_ready: instr_done = 1, go to FETCH.
  - RTYPEEX(6): AluSrcA = 1, AluSrcB = 00, AluOp = 1111. Go to RTYPEWB.
  - RTYPEWB(7): RegWrite = 1, RegDst = 1, MemtoReg = 0, instr_done = 1. Go to FETCH.
  - IEX(8): AluSrcA = 1, AluSrcB = 10. AluOp = 0010 (addi), 0111 (slti), 0000 (andi), 0001 (ori). Go to IWB.
  - IWB(9): RegWrite = 1, RegDst = 0, MemtoReg = 0, instr_done = 1. Go to FETCH.
  - BEQEX(10): AluSrcA = 1, AluSrcB = 00, AluOp = 0110, Branch = 1, PCSrc = 01, instr_done = 1. Go to FETCH.
  - JEX(11): PCWrite = 1, PCSrc = 10, instr_done = 1. Go to FETCH.
- Unused encodings 12–15 go to FETCH on the next edge with all outputs 0.
- Latency with mem_ready tied high: R/addi/slti/andi/ori = 4 cycles, lw = 5, sw = 4, beq = 3, j = 3.
- Each memory wait cycle adds 1 cycle; control outputs hold steady across waits.
- mem_ready arriving outside FETCH/MEMRD/MEMWR is ignored.
- op changes outside DECODE/MEMADR/IEX have no effect.

Test Plan:
- Reset held 3 cycles mid-MEMWR → all outputs 0 during reset. After release: state = 0, mem_req = 1, MemWrite never pulses after reset asserts.
- mem_ready = 1, op = 000000 → state sequence 0, 1, 6, 7. IRWrite = PCWrite = 1 in cycle 0; AluOp = 1111 in cycle 2; RegWrite = RegDst = 1 and instr_done = 1 in cycle 3.
- op = 100011 with mem_ready low for 2 cycles in MEMRD → sequence 0, 1, 2, 3, 3, 3, 4. IorD = 1 throughout MEMRD; MemtoReg = RegWrite = 1 in state 4; 7 cycles total.
- op = 001010 then 001101 → AluOp = 0111, then 0001, in IEX. RegDst = 0 in IWB.
- op = 000100 → BEQEX: Branch = 1, PCSrc = 01, AluOp = 0110, PCWrite = 0. op = 000010 → JEX: PCWrite = 1, PCSrc = 10.
- op = 111111 → DECODE asserts illegal_op = 1 and instr_done = 1; next state = 0; no RegWrite/MemWrite pulses.
